// File: rtl/msi_pkg.sv
// Shared types for the MSI cache controller: bus message codes, line states and
// controller states, plus the mapping from a pending line state to its bus message.
package msi_pkg;

    typedef enum logic [1:0] {
        BusRd   = 2'b00,
        BusRdX  = 2'b01,
        BusUpgr = 2'b10,
        Flush   = 2'b11
    } bus_msg_e;

    typedef enum logic [2:0] {
        LnInvalid  = 3'd0,
        LnInv2Sha  = 3'd1,
        LnInv2Mod  = 3'd2,
        LnShared   = 3'd3,
        LnSha2Mod  = 3'd4,
        LnModified = 3'd5
    } line_state_e;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StDone     = 3'd1,
        StReq      = 3'd2,
        StIssue    = 3'd3,
        StWaitData = 3'd4
    } ctrl_state_e;

    function automatic bus_msg_e pending_msg(line_state_e st);
        bus_msg_e msg;
        case (st)
            LnInv2Mod: msg = BusRdX;
            LnSha2Mod: msg = BusUpgr;
            default:   msg = BusRd;
        endcase
        return msg;
    endfunction

endpackage

// File: rtl/msi_cache_ctrl_if.sv
// Processor, bus, snoop and fill signals of one MSI cache controller.
// master is the controller side, slave is the processor/bus environment.
interface msi_cache_ctrl_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CPU_W  = 2
);
    logic              pr_rd_i;
    logic              pr_wr_i;
    logic [ADDR_W-1:0] pr_addr_i;
    logic              pr_busy_o;
    logic              pr_done_o;

    logic              bus_req_o;
    logic              bus_gnt_i;
    logic              bus_valid_o;
    logic [1:0]        bus_msg_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [CPU_W-1:0]  bus_cpu_o;

    logic              snp_valid_i;
    logic [1:0]        snp_msg_i;
    logic [ADDR_W-1:0] snp_addr_i;
    logic [CPU_W-1:0]  snp_cpu_i;
    logic              data_valid_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic              flush_o;
    logic [ADDR_W-1:0] flush_addr_o;

    modport master (
        input  pr_rd_i, pr_wr_i, pr_addr_i, bus_gnt_i,
        input  snp_valid_i, snp_msg_i, snp_addr_i, snp_cpu_i, data_valid_i, data_addr_i,
        output pr_busy_o, pr_done_o, bus_req_o, bus_valid_o, bus_msg_o, bus_addr_o,
        output bus_cpu_o, flush_o, flush_addr_o
    );

    modport slave (
        output pr_rd_i, pr_wr_i, pr_addr_i, bus_gnt_i,
        output snp_valid_i, snp_msg_i, snp_addr_i, snp_cpu_i, data_valid_i, data_addr_i,
        input  pr_busy_o, pr_done_o, bus_req_o, bus_valid_o, bus_msg_o, bus_addr_o,
        input  bus_cpu_o, flush_o, flush_addr_o
    );
endinterface

// File: rtl/msi_line_fsm.sv
// Next-state logic for one cache line: the snoop effect is resolved first, then the
// processor request, fill data or upgrade completion is applied to the post-snoop state.
module msi_line_fsm
    import msi_pkg::*;
(
    input  line_state_e line_q_i,
    input  logic        snp_hit_i,
    input  bus_msg_e    snp_msg_i,
    input  logic        acc_i,
    input  logic        acc_wr_i,
    input  logic        fill_i,
    input  logic        upgr_done_i,
    output line_state_e snp_state_o,
    output line_state_e line_d_o,
    output logic        flush_o
);

    always_comb begin
        snp_state_o = line_q_i;
        flush_o     = 1'b0;
        if (snp_hit_i) begin
            case (line_q_i)
                LnShared: begin
                    if (snp_msg_i == BusRdX || snp_msg_i == BusUpgr) snp_state_o = LnInvalid;
                end
                // Lost the upgrade race: the pending BusUpgr must now fetch the line.
                LnSha2Mod: begin
                    if (snp_msg_i == BusRdX || snp_msg_i == BusUpgr) snp_state_o = LnInv2Mod;
                end
                LnModified: begin
                    if (snp_msg_i == BusRd) begin
                        snp_state_o = LnShared;
                        flush_o     = 1'b1;
                    end else if (snp_msg_i == BusRdX) begin
                        snp_state_o = LnInvalid;
                        flush_o     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        line_d_o = snp_state_o;
        if (acc_i) begin
            if (snp_state_o == LnInvalid) begin
                line_d_o = acc_wr_i ? LnInv2Mod : LnInv2Sha;
            end else if (acc_wr_i && snp_state_o == LnShared) begin
                line_d_o = LnSha2Mod;
            end
        end
        if (fill_i) begin
            if (snp_state_o == LnInv2Sha) line_d_o = LnShared;
            if (snp_state_o == LnInv2Mod) line_d_o = LnModified;
        end
        if (upgr_done_i && snp_state_o == LnSha2Mod) line_d_o = LnModified;
    end

endmodule

// File: rtl/msi_cache_ctrl.sv
// MSI snooping cache controller: one outstanding processor request, per-line state kept
// here and advanced by msi_line_fsm instances; all interface outputs are registered.
module msi_cache_ctrl
    import msi_pkg::*;
#(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned CPU_ID    = 0,
    parameter int unsigned CPU_W     = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    msi_cache_ctrl_if.master bus
);

    localparam int unsigned ADDR_W = $clog2(NUM_LINES);

    ctrl_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    line_state_e       line_q    [NUM_LINES];
    line_state_e       line_d    [NUM_LINES];
    line_state_e       snp_state [NUM_LINES];
    logic [NUM_LINES-1:0] flush_req;

    logic              pr_busy_q;
    logic              pr_done_q;
    logic              bus_req_q;
    logic              bus_valid_q;
    bus_msg_e          bus_msg_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [CPU_W-1:0]  bus_cpu_q;
    logic              flush_q;
    logic [ADDR_W-1:0] flush_addr_q;

    logic        snp_foreign;
    logic        accept;
    logic        hit;
    logic        fill;
    line_state_e req_st;
    line_state_e pend_st;

    always_comb begin
        snp_foreign = bus.snp_valid_i && (bus.snp_cpu_i != CPU_W'(CPU_ID));
        accept      = (state_q == StIdle) && (bus.pr_rd_i || bus.pr_wr_i);
        req_st      = snp_state[bus.pr_addr_i];
        pend_st     = snp_state[addr_q];
        hit         = bus.pr_wr_i ? (req_st == LnModified)
                                  : (req_st == LnShared || req_st == LnModified);
        fill        = (state_q == StWaitData) && bus.data_valid_i &&
                      (bus.data_addr_i == addr_q);
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        logic line_snp;
        logic line_acc;
        logic line_fill;
        logic line_upgr;

        always_comb begin
            line_snp  = snp_foreign && (bus.snp_addr_i == ADDR_W'(i));
            line_acc  = accept && (bus.pr_addr_i == ADDR_W'(i));
            line_fill = fill && (addr_q == ADDR_W'(i));
            line_upgr = (state_q == StIssue) && (addr_q == ADDR_W'(i));
        end

        msi_line_fsm u_line_fsm (
            .line_q_i    (line_q[i]),
            .snp_hit_i   (line_snp),
            .snp_msg_i   (bus_msg_e'(bus.snp_msg_i)),
            .acc_i       (line_acc),
            .acc_wr_i    (bus.pr_wr_i),
            .fill_i      (line_fill),
            .upgr_done_i (line_upgr),
            .snp_state_o (snp_state[i]),
            .line_d_o    (line_d[i]),
            .flush_o     (flush_req[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            pr_busy_q    <= 1'b0;
            pr_done_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_msg_q    <= BusRd;
            bus_addr_q   <= '0;
            bus_cpu_q    <= '0;
            flush_q      <= 1'b0;
            flush_addr_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) line_q[i] <= LnInvalid;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) line_q[i] <= line_d[i];
            flush_q      <= |flush_req;
            flush_addr_q <= (|flush_req) ? bus.snp_addr_i : '0;
            pr_done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        pr_busy_q <= 1'b1;
                        if (hit) begin
                            state_q   <= StDone;
                            pr_done_q <= 1'b1;
                        end else begin
                            state_q   <= StReq;
                            bus_req_q <= 1'b1;
                            addr_q    <= bus.pr_addr_i;
                        end
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    pr_busy_q <= 1'b0;
                end
                StReq: begin
                    // Message follows the post-snoop line state, so a lost upgrade goes out as BusRdX.
                    if (bus.bus_gnt_i) begin
                        state_q     <= StIssue;
                        bus_req_q   <= 1'b0;
                        bus_valid_q <= 1'b1;
                        bus_msg_q   <= pending_msg(pend_st);
                        bus_addr_q  <= addr_q;
                        bus_cpu_q   <= CPU_W'(CPU_ID);
                    end
                end
                StIssue: begin
                    bus_valid_q <= 1'b0;
                    bus_msg_q   <= BusRd;
                    bus_addr_q  <= '0;
                    bus_cpu_q   <= '0;
                    if (pend_st == LnSha2Mod) begin
                        state_q   <= StDone;
                        pr_done_q <= 1'b1;
                    end else begin
                        state_q <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (fill) begin
                        state_q   <= StDone;
                        pr_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.pr_busy_o    = pr_busy_q;
    assign bus.pr_done_o    = pr_done_q;
    assign bus.bus_req_o    = bus_req_q;
    assign bus.bus_valid_o  = bus_valid_q;
    assign bus.bus_msg_o    = bus_msg_q;
    assign bus.bus_addr_o   = bus_addr_q;
    assign bus.bus_cpu_o    = bus_cpu_q;
    assign bus.flush_o      = flush_q;
    assign bus.flush_addr_o = flush_addr_q;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Self-checking bench for msi_cache_ctrl (NUM_LINES=4, CPU_ID=1): directed scenarios plus
// randomized accesses and snoops checked against a stable-state MSI model.
module tb_msi_cache_ctrl;
    import msi_pkg::*;

    typedef enum int {MI, MS, MM} mst_e;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    mst_e model [4];

    msi_cache_ctrl_if #(.ADDR_W(2), .CPU_W(2)) bif ();

    msi_cache_ctrl #(.NUM_LINES(4), .CPU_ID(1), .CPU_W(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic line_state_e exp_line(mst_e m);
        case (m)
            MS:      return LnShared;
            MM:      return LnModified;
            default: return LnInvalid;
        endcase
    endfunction

    task automatic model_snoop(input logic [1:0] a, input logic [1:0] m, input logic [1:0] c,
                               output bit fl);
        fl = 1'b0;
        if (c != 2'd1) begin
            if (model[a] == MS && (m == BusRdX || m == BusUpgr)) model[a] = MI;
            else if (model[a] == MM && m == BusRd) begin model[a] = MS; fl = 1'b1; end
            else if (model[a] == MM && m == BusRdX) begin model[a] = MI; fl = 1'b1; end
        end
    endtask

    // Drives one processor access (optionally with a snoop in the acceptance cycle) and
    // plays bus arbiter / memory until the controller returns to idle.
    task automatic run_access(input bit wr, input bit both, input logic [1:0] addr,
                              input int gnt_dly, input int data_dly,
                              input bit snp_en, input logic [1:0] snp_m,
                              input logic [1:0] snp_a, input logic [1:0] snp_c,
                              output int req_cycles, output int n_valid,
                              output logic [1:0] msg, output logic [1:0] baddr,
                              output logic [1:0] bcpu, output int n_done, output int lat,
                              output logic fl, output logic [1:0] fa, output bit tmo);
        int gcnt = 0;
        int dcnt = 0;
        bit issued = 1'b0;
        req_cycles = 0; n_valid = 0; n_done = 0; lat = 0; tmo = 1'b1;
        msg = 2'b00; baddr = 2'b00; bcpu = 2'b00; fl = 1'b0; fa = 2'b00;
        bif.pr_rd_i   = !wr || both;
        bif.pr_wr_i   = wr;
        bif.pr_addr_i = addr;
        if (snp_en) begin
            bif.snp_valid_i = 1'b1; bif.snp_msg_i = snp_m;
            bif.snp_addr_i  = snp_a; bif.snp_cpu_i = snp_c;
        end
        tick();
        bif.pr_rd_i = 1'b0; bif.pr_wr_i = 1'b0; bif.snp_valid_i = 1'b0;
        fl = bif.flush_o; fa = bif.flush_addr_o;
        for (int c = 0; c < 60; c++) begin
            if (bif.bus_req_o) req_cycles++;
            if (bif.pr_done_o) begin n_done++; lat = c + 1; end
            if (!bif.pr_busy_o) begin tmo = 1'b0; break; end
            bif.data_valid_i = 1'b0;
            if (issued && !bif.bus_valid_o && msg != BusUpgr) begin
                if (dcnt >= data_dly) begin
                    bif.data_valid_i = 1'b1; bif.data_addr_i = addr; issued = 1'b0;
                end
                dcnt++;
            end
            if (bif.bus_valid_o) begin
                n_valid++; msg = bif.bus_msg_o; baddr = bif.bus_addr_o;
                bcpu = bif.bus_cpu_o; issued = 1'b1; dcnt = 0;
            end
            if (bif.bus_req_o) begin
                bif.bus_gnt_i = (gcnt >= gnt_dly);
                gcnt++;
            end else begin
                bif.bus_gnt_i = 1'b0;
            end
            tick();
        end
        bif.bus_gnt_i = 1'b0; bif.data_valid_i = 1'b0;
    endtask

    task automatic do_snoop(input logic [1:0] a, input logic [1:0] m, input logic [1:0] c,
                            output logic fl, output logic [1:0] fa);
        bif.snp_valid_i = 1'b1; bif.snp_msg_i = m; bif.snp_addr_i = a; bif.snp_cpu_i = c;
        tick();
        bif.snp_valid_i = 1'b0;
        fl = bif.flush_o; fa = bif.flush_addr_o;
        tick();
    endtask

    function automatic logic [12:0] all_outs();
        return {bif.pr_busy_o, bif.pr_done_o, bif.bus_req_o, bif.bus_valid_o, bif.bus_msg_o,
                bif.bus_addr_o, bif.bus_cpu_o, bif.flush_o, bif.flush_addr_o};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++;
        if (all_outs() !== 13'd0) begin
            bad++; $display("FAIL reset_outs got=%h want=0", all_outs());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dut.line_q[i] !== LnInvalid) begin
                bad++; $display("FAIL reset_line%0d got=%0d want=%0d", i, dut.line_q[i], LnInvalid);
            end
            model[i] = MI;
        end
        rst = 1'b1;
        tick();
        total++;
        if (bif.pr_busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy=%b want=0", bif.pr_busy_o);
        end
    endtask

    task automatic test_read_miss();
        int rq, nv, nd, lt; logic [1:0] m, ba, bc, fa; logic fl; bit to;
        run_access(1'b0, 1'b0, 2'd2, 3, 2, 1'b0, 2'd0, 2'd0, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        total++;
        if (to || nv != 1 || rq != 4 || nd != 1) begin
            bad++; $display("FAIL rd_miss_flow to=%0b valid=%0d req=%0d done=%0d want 0/1/4/1",
                            to, nv, rq, nd);
        end
        total++;
        if ({m, ba, bc} !== {BusRd, 2'd2, 2'd1}) begin
            bad++; $display("FAIL rd_miss_msg msg=%0d addr=%0d cpu=%0d want 0/2/1", m, ba, bc);
        end
        total++;
        if (dut.line_q[2] !== LnShared) begin
            bad++; $display("FAIL rd_miss_line got=%0d want=%0d", dut.line_q[2], LnShared);
        end
        model[2] = MS;
    endtask

    task automatic test_write_upgrade();
        int rq, nv, nd, lt; logic [1:0] m, ba, bc, fa; logic fl; bit to;
        run_access(1'b1, 1'b0, 2'd2, 0, 0, 1'b0, 2'd0, 2'd0, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        total++;
        if (to || nv != 1 || m !== BusUpgr || ba !== 2'd2 || nd != 1 || rq != 1) begin
            bad++; $display("FAIL upgr_flow to=%0b valid=%0d msg=%0d addr=%0d done=%0d req=%0d",
                            to, nv, m, ba, nd, rq);
        end
        total++;
        if (dut.line_q[2] !== LnModified) begin
            bad++; $display("FAIL upgr_line got=%0d want=%0d", dut.line_q[2], LnModified);
        end
        run_access(1'b1, 1'b0, 2'd2, 0, 0, 1'b0, 2'd0, 2'd0, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        total++;
        if (to || nv != 0 || rq != 0 || nd != 1 || lt != 1) begin
            bad++; $display("FAIL wr_hit to=%0b valid=%0d req=%0d done=%0d lat=%0d want 0/0/0/1/1",
                            to, nv, rq, nd, lt);
        end
        model[2] = MM;
    endtask

    task automatic test_snoop_flush();
        int rq, nv, nd, lt; logic [1:0] m, ba, bc, fa; logic fl; bit to;
        run_access(1'b1, 1'b0, 2'd3, 1, 1, 1'b0, 2'd0, 2'd0, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        total++;
        if (to || m !== BusRdX || dut.line_q[3] !== LnModified) begin
            bad++; $display("FAIL wr_miss to=%0b msg=%0d line=%0d want 0/1/%0d",
                            to, m, dut.line_q[3], LnModified);
        end
        do_snoop(2'd3, BusRd, 2'd2, fl, fa);
        total++;
        if (fl !== 1'b1 || fa !== 2'd3 || dut.line_q[3] !== LnShared) begin
            bad++; $display("FAIL snoop_flush flush=%b addr=%0d line=%0d want 1/3/%0d",
                            fl, fa, dut.line_q[3], LnShared);
        end
        do_snoop(2'd3, BusRdX, 2'd1, fl, fa);
        total++;
        if (fl !== 1'b0 || dut.line_q[3] !== LnShared) begin
            bad++; $display("FAIL snoop_own flush=%b line=%0d want 0/%0d",
                            fl, dut.line_q[3], LnShared);
        end
        // Invalidating snoop in the acceptance cycle turns the read hit into a miss.
        run_access(1'b0, 1'b0, 2'd3, 0, 0, 1'b1, BusRdX, 2'd3, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        total++;
        if (to || nv != 1 || m !== BusRd || nd != 1 || dut.line_q[3] !== LnShared) begin
            bad++; $display("FAIL snoop_then_req to=%0b valid=%0d msg=%0d done=%0d line=%0d",
                            to, nv, m, nd, dut.line_q[3]);
        end
        model[3] = MS;
    endtask

    task automatic test_sha2mod_race();
        int rq, nv, nd, lt; logic [1:0] m, ba, bc, fa; logic fl; bit to;
        run_access(1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 2'd0, 2'd0, 2'd0,
                   rq, nv, m, ba, bc, nd, lt, fl, fa, to);
        bif.pr_wr_i = 1'b1; bif.pr_addr_i = 2'd0;
        tick();
        bif.pr_wr_i = 1'b0;
        total++;
        if (bif.bus_req_o !== 1'b1 || dut.line_q[0] !== LnSha2Mod) begin
            bad++; $display("FAIL race_pending req=%b line=%0d want 1/%0d",
                            bif.bus_req_o, dut.line_q[0], LnSha2Mod);
        end
        bif.snp_valid_i = 1'b1; bif.snp_msg_i = BusUpgr; bif.snp_addr_i = 2'd0;
        bif.snp_cpu_i = 2'd2;
        tick();
        bif.snp_valid_i = 1'b0;
        total++;
        if (dut.line_q[0] !== LnInv2Mod || bif.bus_req_o !== 1'b1 || bif.flush_o !== 1'b0) begin
            bad++; $display("FAIL race_snoop line=%0d req=%b flush=%b want %0d/1/0",
                            dut.line_q[0], bif.bus_req_o, bif.flush_o, LnInv2Mod);
        end
        bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i = 1'b0;
        total++;
        if (bif.bus_valid_o !== 1'b1 || bif.bus_msg_o !== BusRdX || bif.bus_addr_o !== 2'd0) begin
            bad++; $display("FAIL race_msg valid=%b msg=%0d addr=%0d want 1/1/0",
                            bif.bus_valid_o, bif.bus_msg_o, bif.bus_addr_o);
        end
        tick();
        bif.data_valid_i = 1'b1; bif.data_addr_i = 2'd1;
        tick();
        bif.data_valid_i = 1'b0;
        total++;
        if (bif.pr_done_o !== 1'b0 || bif.pr_busy_o !== 1'b1) begin
            bad++; $display("FAIL race_wrong_data done=%b busy=%b want 0/1",
                            bif.pr_done_o, bif.pr_busy_o);
        end
        bif.data_valid_i = 1'b1; bif.data_addr_i = 2'd0;
        tick();
        bif.data_valid_i = 1'b0;
        total++;
        if (bif.pr_done_o !== 1'b1 || dut.line_q[0] !== LnModified) begin
            bad++; $display("FAIL race_fill done=%b line=%0d want 1/%0d",
                            bif.pr_done_o, dut.line_q[0], LnModified);
        end
        tick();
        model[0] = MM;
    endtask

    task automatic test_reset_mid_wait();
        bif.pr_rd_i = 1'b1; bif.pr_addr_i = 2'd1;
        tick();
        bif.pr_rd_i = 1'b0; bif.bus_gnt_i = 1'b1;
        tick();
        bif.bus_gnt_i = 1'b0;
        tick();
        total++;
        if (bif.pr_busy_o !== 1'b1 || dut.line_q[1] !== LnInv2Sha) begin
            bad++; $display("FAIL midwait_setup busy=%b line=%0d want 1/%0d",
                            bif.pr_busy_o, dut.line_q[1], LnInv2Sha);
        end
        rst = 1'b0;
        tick();
        total++;
        if (all_outs() !== 13'd0) begin
            bad++; $display("FAIL midwait_reset_outs got=%h want=0", all_outs());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dut.line_q[i] !== LnInvalid) begin
                bad++; $display("FAIL midwait_line%0d got=%0d want=%0d", i, dut.line_q[i], LnInvalid);
            end
            model[i] = MI;
        end
        rst = 1'b1;
        bif.data_valid_i = 1'b1; bif.data_addr_i = 2'd1;
        tick();
        bif.data_valid_i = 1'b0;
        total++;
        if (bif.pr_done_o !== 1'b0 || bif.pr_busy_o !== 1'b0 || dut.line_q[1] !== LnInvalid) begin
            bad++; $display("FAIL late_data done=%b busy=%b line=%0d want 0/0/%0d",
                            bif.pr_done_o, bif.pr_busy_o, dut.line_q[1], LnInvalid);
        end
    endtask

    task automatic test_random();
        int rq, nv, nd, lt; logic [1:0] m, ba, bc, fa; logic fl; bit to;
        bit efl, wr, both, sen, hit;
        logic [1:0] a, sm, sa, sc, emsg;
        int gd, dd;
        for (int it = 0; it < 60; it++) begin
            a  = 2'($urandom_range(0, 3));
            sm = 2'($urandom_range(0, 3));
            sa = 2'($urandom_range(0, 3));
            sc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                model_snoop(sa, sm, sc, efl);
                do_snoop(sa, sm, sc, fl, fa);
                total++;
                if (fl !== efl || (efl && fa !== sa) || dut.line_q[sa] !== exp_line(model[sa])) begin
                    bad++; $display("FAIL rnd_snoop it=%0d flush=%b/%b faddr=%0d/%0d line=%0d/%0d",
                                    it, fl, efl, fa, sa, dut.line_q[sa], exp_line(model[sa]));
                end
            end else begin
                wr   = 1'($urandom_range(0, 1));
                both = wr && ($urandom_range(0, 1) == 1);
                sen  = ($urandom_range(0, 3) == 0);
                gd   = $urandom_range(0, 3);
                dd   = $urandom_range(0, 3);
                efl  = 1'b0;
                if (sen) model_snoop(sa, sm, sc, efl);
                hit  = wr ? (model[a] == MM) : (model[a] != MI);
                emsg = !wr ? BusRd : (model[a] == MS ? BusUpgr : BusRdX);
                run_access(wr, both, a, gd, dd, sen, sm, sa, sc,
                           rq, nv, m, ba, bc, nd, lt, fl, fa, to);
                if (wr) model[a] = MM;
                else if (model[a] == MI) model[a] = MS;
                total++;
                if (to || nd != 1 || fl !== efl) begin
                    bad++; $display("FAIL rnd_done it=%0d to=%0b done=%0d flush=%b/%b",
                                    it, to, nd, fl, efl);
                end
                total++;
                if (hit && (nv != 0 || rq != 0 || lt != 1)) begin
                    bad++; $display("FAIL rnd_hit it=%0d valid=%0d req=%0d lat=%0d want 0/0/1",
                                    it, nv, rq, lt);
                end else if (!hit && (nv != 1 || rq != gd + 1 || m !== emsg || ba !== a ||
                                      bc !== 2'd1)) begin
                    bad++; $display("FAIL rnd_miss it=%0d valid=%0d req=%0d/%0d msg=%0d/%0d addr=%0d/%0d cpu=%0d",
                                    it, nv, rq, gd + 1, m, emsg, ba, a, bc);
                end
                total++;
                if (dut.line_q[a] !== exp_line(model[a])) begin
                    bad++; $display("FAIL rnd_line it=%0d addr=%0d got=%0d want=%0d",
                                    it, a, dut.line_q[a], exp_line(model[a]));
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0;
        bif.pr_rd_i = 1'b0; bif.pr_wr_i = 1'b0; bif.pr_addr_i = '0; bif.bus_gnt_i = 1'b0;
        bif.snp_valid_i = 1'b0; bif.snp_msg_i = '0; bif.snp_addr_i = '0; bif.snp_cpu_i = '0;
        bif.data_valid_i = 1'b0; bif.data_addr_i = '0;
        test_reset();
        test_read_miss();
        test_write_upgrade();
        test_snoop_flush();
        test_sha2mod_race();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
